regfile_write_arbiter: RTL



---
 rtl/regfile_write_arbiter.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/regfile_write_arbiter.sv
// Arbitrates the single register-file write port between ALU, load and mul/div writeback,
// registers the winning write, and tracks outstanding destination registers for hazard checks.
module regfile_write_arbiter #(
    parameter int DATA_WIDTH   = 32,
    parameter int SEL_WIDTH    = 4,
    parameter int NUM_REGS     = 16,
    parameter int STARVE_LIMIT = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  issue_valid,
    input  logic [SEL_WIDTH-1:0]  issue_sel,
    input  logic                  alu_valid,
    output logic                  alu_ready,
    input  logic [SEL_WIDTH-1:0]  alu_sel,
    input  logic [DATA_WIDTH-1:0] alu_data,
    input  logic                  ld_valid,
    output logic                  ld_ready,
    input  logic [SEL_WIDTH-1:0]  ld_sel,
    input  logic [DATA_WIDTH-1:0] ld_data,
    input  logic                  md_valid,
    output logic                  md_ready,
    input  logic [SEL_WIDTH-1:0]  md_sel,
    input  logic [DATA_WIDTH-1:0] md_data,
    output logic                  out_write_en,
    output logic [SEL_WIDTH-1:0]  out_write_sel,
    output logic [DATA_WIDTH-1:0] out_write_data,
    output logic [NUM_REGS-1:0]   out_pending,
    output logic                  out_err
);

    localparam int CW = $clog2(STARVE_LIMIT + 1);

    typedef enum logic {
        RR_LD = 1'b0,
        RR_MD = 1'b1
    } rr_e;

    rr_e                   rr_q, rr_d;
    logic [CW-1:0]         starve_q, starve_d;
    logic                  write_en_q, write_en_d;
    logic [SEL_WIDTH-1:0]  write_sel_q, write_sel_d;
    logic [DATA_WIDTH-1:0] write_data_q, write_data_d;
    logic [NUM_REGS-1:0]   pend_q, pend_d;
    logic                  err_q, err_d;

    logic                  ldmd_valid;
    logic                  force_ldmd;
    logic                  pick_md;
    logic                  grant_alu;
    logic                  grant_ld;
    logic                  grant_md;
    logic                  xfer;
    logic [SEL_WIDTH-1:0]  xfer_sel;
    logic [DATA_WIDTH-1:0] xfer_data;
    logic                  target_pending;

    // Grants are gated by rst_n so every ready reads 0 while reset is held.
    always_comb begin
        ldmd_valid = ld_valid | md_valid;
        pick_md    = (rr_q == RR_MD) ? md_valid : !ld_valid;
        force_ldmd = (starve_q == CW'(STARVE_LIMIT)) && ldmd_valid;
        grant_alu  = rst_n && alu_valid && !force_ldmd;
        grant_ld   = rst_n && !grant_alu && ldmd_valid && !pick_md;
        grant_md   = rst_n && !grant_alu && ldmd_valid && pick_md;
        xfer       = grant_alu | grant_ld | grant_md;
    end

    assign alu_ready = grant_alu;
    assign ld_ready  = grant_ld;
    assign md_ready  = grant_md;

    always_comb begin
        xfer_sel  = alu_sel;
        xfer_data = alu_data;
        if (grant_ld) begin
            xfer_sel  = ld_sel;
            xfer_data = ld_data;
        end else if (grant_md) begin
            xfer_sel  = md_sel;
            xfer_data = md_data;
        end
    end

    always_comb begin
        rr_d     = rr_q;
        starve_d = starve_q;
        if (grant_ld) begin
            rr_d     = RR_MD;
            starve_d = '0;
        end else if (grant_md) begin
            rr_d     = RR_LD;
            starve_d = '0;
        end else if (grant_alu && ldmd_valid && (starve_q != CW'(STARVE_LIMIT))) begin
            starve_d = starve_q + CW'(1);
        end
    end

    // A newly issued producer must win over a retiring write to the same register.
    always_comb begin
        write_en_d     = xfer && (xfer_sel != '0);
        write_sel_d    = write_sel_q;
        write_data_d   = write_data_q;
        pend_d         = pend_q;
        err_d          = err_q;
        target_pending = 1'b0;
        if (write_en_d) begin
            write_sel_d  = xfer_sel;
            write_data_d = xfer_data;
        end
        for (int i = 1; i < NUM_REGS; i++) begin
            if (write_en_d && (xfer_sel == SEL_WIDTH'(i))) begin
                target_pending = pend_q[i];
                pend_d[i]      = 1'b0;
            end
        end
        for (int i = 1; i < NUM_REGS; i++) begin
            if (issue_valid && (issue_sel == SEL_WIDTH'(i))) begin
                pend_d[i] = 1'b1;
            end
        end
        pend_d[0] = 1'b0;
        if (write_en_d && !target_pending) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_q         <= RR_LD;
            starve_q     <= '0;
            write_en_q   <= 1'b0;
            write_sel_q  <= '0;
            write_data_q <= '0;
            pend_q       <= '0;
            err_q        <= 1'b0;
        end else begin
            rr_q         <= rr_d;
            starve_q     <= starve_d;
            write_en_q   <= write_en_d;
            write_sel_q  <= write_sel_d;
            write_data_q <= write_data_d;
            pend_q       <= pend_d;
            err_q        <= err_d;
        end
    end

    assign out_write_en   = write_en_q;
    assign out_write_sel  = write_sel_q;
    assign out_write_data = write_data_q;
    assign out_pending    = pend_q;
    assign out_err        = err_q;

endmodule
